// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags, sticky errors and synchronous flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered with one-cycle latency.
module fifo_sync_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     pop,
    output logic [DATA_W-1:0]        data_out,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_en, rd_en;

    // Flags decode the count register directly so they track it in the same cycle.
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A flush blocks both sides so nothing lands in or leaves storage that cycle.
    assign wr_en = push & ~full  & ~clear;
    assign rd_en = pop  & ~empty & ~clear;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (push & full);
        underflow_d = underflow_q | (pop & empty);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented as soon as it exists; pop only advances the pointer.
    assign data_out = empty ? '0 : mem[rd_ptr_q];
`else
    logic [DATA_W-1:0] data_out_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_q <= '0;
        end else if (clear) begin
            data_out_q <= '0;
        end else if (rd_en) begin
            data_out_q <= mem[rd_ptr_q];
        end
    end

    assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param (DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2).
module tb_fifo_sync_param;
    logic       clk;
    logic       reset;
    logic       clear;
    logic       push;
    logic [7:0] data_in;
    logic       full;
    logic       almost_full;
    logic       pop;
    logic [7:0] data_out;
    logic       empty;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_errors = 0;

    fifo_sync_param #(
        .DATA_W  (8),
        .DEPTH   (16),
        .AF_LEVEL(14),
        .AE_LEVEL(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .push        (push),
        .data_in     (data_in),
        .full        (full),
        .almost_full (almost_full),
        .pop         (pop),
        .data_out    (data_out),
        .empty       (empty),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; when chk is set the word popped this cycle must equal exp_rd
    // (before the edge in FWFT mode, after it in registered mode).
    task automatic do_cycle(input logic p, input logic [7:0] d, input logic q,
                            input logic chk, input logic [7:0] exp_rd, input string tag);
        push    = p;
        data_in = d;
        pop     = q;
`ifdef FIFO_FWFT_EN
        #1;
        if (chk) check_val(tag, data_out, exp_rd);
`endif
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
`ifndef FIFO_FWFT_EN
        if (chk) check_val(tag, data_out, exp_rd);
`endif
        $display("cycle %s push=%0b din=%02h pop=%0b count=%0d dout=%02h", tag, p, d, q, count, data_out);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        clear   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 8'h00;
        #2;
        check_val("rst_count", count, 0);
        check_val("rst_empty", empty, 1);
        check_val("rst_aempty", almost_empty, 1);
        check_val("rst_full", full, 0);
        check_val("rst_afull", almost_full, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_unf", underflow, 0);
        check_val("rst_dout", data_out, 0);
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        // Fill with 0x00..0x0F; almost_full from count 14, full at 16.
        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, "fill");
            check_val("fill_count", count, i + 1);
            check_val("fill_afull", almost_full, (i + 1 >= 14) ? 1 : 0);
            check_val("fill_aempty", almost_empty, (i + 1 <= 2) ? 1 : 0);
        end
        check_val("fill_full", full, 1);

        do_cycle(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, "ovf");
        check_val("ovf_flag", overflow, 1);
        check_val("ovf_count", count, 16);

        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'(i), "drain");
            check_val("drain_count", count, 15 - i);
        end
        check_val("drain_empty", empty, 1);
        check_val("drain_full", full, 0);

        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "unf");
        check_val("unf_flag", underflow, 1);
        check_val("unf_count", count, 0);
        check_val("ovf_sticky", overflow, 1);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "idle");
        check_val("unf_sticky", underflow, 1);

        do_clear();
        check_val("clr_ovf", overflow, 0);
        check_val("clr_unf", underflow, 0);
        check_val("clr_count", count, 0);
        check_val("clr_dout", data_out, 0);

        // Steady-state streaming at count 8; 28 writes wraps both pointers.
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00, "pre8");
        check_val("pre8_count", count, 8);
        for (int k = 0; k < 20; k++) begin
            do_cycle(1'b1, 8'(8'h18 + k), 1'b1, 1'b1, 8'(8'h10 + k), "stream");
            check_val("stream_count", count, 8);
        end
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h24 + i), "post8");
        check_val("post8_empty", empty, 1);
        check_val("stream_ovf", overflow, 0);
        check_val("stream_unf", underflow, 0);

        // Full with push+pop: pop wins, push rejected.
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 8'h00, "fill2");
        do_cycle(1'b1, 8'h55, 1'b1, 1'b1, 8'h30, "full_pp");
        check_val("full_pp_count", count, 15);
        check_val("full_pp_ovf", overflow, 1);
        do_clear();

        // Empty with push+pop: push wins, pop rejected.
        do_cycle(1'b1, 8'h66, 1'b1, 1'b0, 8'h00, "empty_pp");
        check_val("empty_pp_count", count, 1);
        check_val("empty_pp_unf", underflow, 1);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'h66, "empty_pp_rd");
        check_val("empty_pp_end", count, 0);
        do_clear();

        // Asynchronous reset mid-cycle at count 5.
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00, "pre5");
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'h40, "pre5_rd");
        do_cycle(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, "pre5_wr");
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'h41, "pre5_rd2");
        check_val("pre5_count", count, 5);
        #3 reset = 1'b0;
        #1;
        check_val("arst_count", count, 0);
        check_val("arst_empty", empty, 1);
        check_val("arst_aempty", almost_empty, 1);
        check_val("arst_dout", data_out, 0);
        check_val("arst_afull", almost_full, 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Clear with push: nothing written, count 0.
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 8'h00, "pre_clr");
        push    = 1'b1;
        data_in = 8'h77;
        do_clear();
        push = 1'b0;
        check_val("clrp_count", count, 0);
        check_val("clrp_empty", empty, 1);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "clrp_idle");
        check_val("clrp_count2", count, 0);

        // Single word through an empty FIFO.
        do_cycle(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, "word");
`ifdef FIFO_FWFT_EN
        check_val("fwft_dout", data_out, 8'h5A);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, "word_rd");
        check_val("fwft_empty", empty, 1);
        check_val("fwft_dout0", data_out, 0);
`else
        check_val("reg_dout_nopop", data_out, 0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, "word_rd");
        check_val("reg_empty", empty, 1);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "hold");
        check_val("reg_dout_hold", data_out, 8'h5A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
